// File: rtl/stft_frame_buffer.sv
// -----------------------------------------------------------------------------
// stft_frame_buffer
//
// Purpose
//   Circular sample store that sits behind the STFT control stage. Every new
//   sample (start_compute strobe) is quantised and written into a FFT_SIZE-deep
//   ring. The first frame is requested when the ring first becomes full. After
//   that, a frame is requested every HOP_SIZE samples. An accepted request
//   streams the FFT_SIZE most recent samples, oldest first, over a valid/ready
//   interface.
//
// Ports
//   clk            compute clock
//   RESET          asynchronous, active-low reset
//   start_compute  single-cycle new-sample strobe
//   i_SAMPLE       24-bit signed sample, valid with start_compute
//   o_data         frame sample (word_width bits, signed)
//   o_valid        o_data valid
//   i_ready        downstream accepts o_data (beat = o_valid && i_ready)
//   o_last         high with the final beat of a frame
//   o_busy         high while a frame is being loaded or streamed
//   o_overrun      one-cycle pulse when a frame request is dropped
// -----------------------------------------------------------------------------
module stft_frame_buffer #(
    parameter int FFT_SIZE   = 512,  // power of two
    parameter int HOP_SIZE   = 128,  // 1..FFT_SIZE
    parameter int word_width = 16    // <= 24
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  start_compute,
    input  logic [23:0]           i_SAMPLE,
    output logic [word_width-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_overrun
);

    localparam int ADDR_W = $clog2(FFT_SIZE);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOP_W  = (HOP_SIZE > 1) ? $clog2(HOP_SIZE) : 1;

    localparam logic [CNT_W-1:0]  FILL_FULL = CNT_W'(FFT_SIZE);
    localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(FFT_SIZE - 1);
    localparam logic [HOP_W-1:0]  HOP_END   = HOP_W'(HOP_SIZE - 1);
    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM
    } state_t;

    // Sample ring
    logic [word_width-1:0] mem [FFT_SIZE];
    logic [word_width-1:0] sample_w;

    // State
    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic [HOP_W-1:0]      hop_cnt_q, hop_cnt_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W-1:0]     k_q, k_d;
    logic [word_width-1:0] data_q;
    logic                  overrun_q, overrun_d;

    // Control
    logic                  frame_req;
    logic                  beat_xfer;
    logic                  last_beat;
    logic                  frame_done;
    logic                  req_accept;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;

    // MSB truncation: keep the top word_width bits of the 24-bit sample.
    assign sample_w = i_SAMPLE[23 -: word_width];

    generate
        if (word_width < 24) begin : g_unused_lsb
            logic unused_lsb;
            assign unused_lsb = ^i_SAMPLE[23-word_width:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Write side: pointer, fill level and hop counter
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        hop_cnt_d  = hop_cnt_q;
        frame_req  = 1'b0;
        if (start_compute) begin
            // FFT_SIZE is a power of two, so the pointer wraps by overflow.
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fill_cnt_q != FILL_FULL) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
            if (fill_cnt_q == FILL_LAST) begin
                // Ring just became full: the first frame goes out immediately.
                frame_req = 1'b1;
            end else if (fill_cnt_q == FILL_FULL) begin
                if (hop_cnt_q == HOP_END) begin
                    frame_req = 1'b1;
                    hop_cnt_d = '0;
                end else begin
                    hop_cnt_d = hop_cnt_q + HOP_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read side: handshake, request arbitration, beat index
    // -------------------------------------------------------------------------
    assign beat_xfer  = (state_q == ST_STREAM) && i_ready;
    assign last_beat  = (k_q == K_LAST);
    assign frame_done = beat_xfer && last_beat;
    // A request landing on the final handshake is chained, not dropped.
    assign req_accept = frame_req && ((state_q == ST_IDLE) || frame_done);

    always_comb begin
        base_d    = base_q;
        k_d       = k_q;
        overrun_d = frame_req && !req_accept;
        rd_en     = 1'b0;
        rd_addr   = base_q + k_q + ADDR_W'(1);
        if (req_accept) begin
            // The slot after the sample just written is the oldest one.
            base_d = wr_ptr_d;
        end
        if (state_q == ST_LOAD) begin
            k_d     = '0;
            rd_en   = 1'b1;
            rd_addr = base_q;
        end else if (beat_xfer && !last_beat) begin
            // Prefetch the next beat so o_data is ready without a bubble.
            k_d   = k_q + ADDR_W'(1);
            rd_en = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_accept) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_STREAM;
            ST_STREAM: if (frame_done) state_d = req_accept ? ST_LOAD : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            hop_cnt_q  <= '0;
            base_q     <= '0;
            k_q        <= '0;
            data_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            hop_cnt_q  <= hop_cnt_d;
            base_q     <= base_d;
            k_q        <= k_d;
            overrun_q  <= overrun_d;
            if (rd_en) begin
                data_q <= mem[rd_addr];
            end
        end
    end

    // NOTE: the sample RAM has no reset; its contents are only meaningful
    // once the fill counter says so, and a reset port would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (start_compute) begin
            mem[wr_ptr_q] <= sample_w;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_data    = data_q;
    assign o_valid   = (state_q == ST_STREAM);
    assign o_last    = (state_q == ST_STREAM) && last_beat;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_stft_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_stft_frame_buffer
//
// Directed bench for stft_frame_buffer. The main instance uses the default
// 512/128/16 configuration. A second instance (FFT_SIZE=8, HOP_SIZE=1)
// exercises the frame-per-sample case and the chained-request path.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stft_frame_buffer;

    localparam int N = 512;

    logic        clk = 1'b0;
    logic        RESET;
    logic        start_compute;
    logic [23:0] i_SAMPLE;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;
    logic        o_busy;
    logic        o_overrun;

    logic        s_start;
    logic [23:0] s_sample;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic        s_busy;
    logic        s_overrun;

    always #5 clk = ~clk;

    stft_frame_buffer #(.FFT_SIZE(512), .HOP_SIZE(128), .word_width(16)) dut (
        .clk           (clk),
        .RESET         (RESET),
        .start_compute (start_compute),
        .i_SAMPLE      (i_SAMPLE),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    stft_frame_buffer #(.FFT_SIZE(8), .HOP_SIZE(1), .word_width(16)) dut_small (
        .clk           (clk),
        .RESET         (RESET),
        .start_compute (s_start),
        .i_SAMPLE      (s_sample),
        .o_data        (s_data),
        .o_valid       (s_valid),
        .i_ready       (s_ready),
        .o_last        (s_last),
        .o_busy        (s_busy),
        .o_overrun     (s_overrun)
    );

    int checks = 0;
    int errors = 0;

    // Cycles with o_overrun high, per instance.
    int ovr_cnt   = 0;
    int s_ovr_cnt = 0;
    always @(negedge clk) begin
        if (o_overrun === 1'b1) ovr_cnt++;
        if (s_overrun === 1'b1) s_ovr_cnt++;
    end

    // Beats captured from the main instance.
    logic [15:0] beats [N];
    logic        lastf [N];
    int          nb;
    int          last_cnt;
    int          stall_bad;

    task automatic clear_frame();
        nb        = 0;
        last_cnt  = 0;
        stall_bad = 0;
        for (int i = 0; i < N; i++) begin
            beats[i] = '0;
            lastf[i] = 1'b0;
        end
    endtask

    // Drive one sample for one clock; called and returns on a falling edge.
    task automatic feed_raw(input logic [23:0] v);
        start_compute = 1'b1;
        i_SAMPLE      = v;
        @(negedge clk);
        start_compute = 1'b0;
    endtask

    task automatic feed(input int n);
        feed_raw(24'(n << 8));
    endtask

    // Feeds samples a..b and counts cycles where the block looked active.
    task automatic feed_range(input int a, input int b, output int vbad);
        vbad = 0;
        for (int n = a; n <= b; n++) begin
            feed(n);
            if (o_valid === 1'b1 || o_busy === 1'b1) vbad++;
        end
    endtask

    // Accepts beats until nb reaches stop_at or o_valid drops. i_ready is
    // high with probability ready_pct per cycle. Records beats and counts
    // stalls where o_valid/o_data/o_last moved while not accepted.
    task automatic collect(input int ready_pct, input int stop_at);
        int          guard;
        bit          holding;
        logic [15:0] hd;
        logic        hl;
        guard   = 0;
        holding = 1'b0;
        hd      = '0;
        hl      = 1'b0;
        while (o_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (o_valid === 1'b1 && nb < stop_at && guard < 5000) begin
            if (holding && (o_data !== hd || o_last !== hl)) stall_bad++;
            i_ready = (int'($urandom_range(99)) < ready_pct);
            if (i_ready) begin
                beats[nb] = o_data;
                lastf[nb] = o_last;
                if (o_last === 1'b1) last_cnt++;
                nb++;
                holding = 1'b0;
            end else begin
                holding = 1'b1;
                hd      = o_data;
                hl      = o_last;
            end
            @(negedge clk);
            guard++;
            if (holding && o_valid !== 1'b1) stall_bad++;
        end
        i_ready = 1'b1;
    endtask

    // Counts captured beats that differ from first+i (mod 2^16).
    task automatic count_bad(input int first, output int bad, output int fb);
        bad = 0;
        fb  = -1;
        for (int i = 0; i < nb; i++) begin
            if (beats[i] !== 16'(first + i)) begin
                if (fb < 0) fb = i;
                bad++;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_valid, o_last, o_busy, o_overrun, o_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b ovr=%b d=%h, want all 0",
                     o_valid, o_last, o_busy, o_overrun, o_data);
        end
        checks++;
        if ({s_valid, s_last, s_busy, s_overrun, s_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_small_outputs: got v=%b l=%b b=%b ovr=%b d=%h, want all 0",
                     s_valid, s_last, s_busy, s_overrun, s_data);
        end
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_valid, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: got v=%b b=%b, want 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_first_frame();
        int vbad, bad, fb;
        feed_range(0, 510, vbad);
        checks++;
        if (vbad !== 0) begin
            errors++;
            $display("FAIL t1_no_early_frame: active for %0d cycles, want 0", vbad);
        end
        feed(511);
        checks++;
        if ({o_valid, o_busy} !== 2'b01) begin
            errors++;
            $display("FAIL t1_load_cycle: got v=%b b=%b, want v=0 b=1", o_valid, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'h0000 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL t1_valid_latency: got v=%b d=%h l=%b, want v=1 d=0000 l=0",
                     o_valid, o_data, o_last);
        end
        clear_frame();
        collect(100, N);
        checks++;
        if (nb !== N) begin
            errors++;
            $display("FAIL t1_beat_count: got %0d, want %0d", nb, N);
        end
        count_bad(0, bad, fb);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL t1_data: %0d bad beats, first at %0d got %h want %h",
                     bad, fb, beats[fb], 16'(fb));
        end
        checks++;
        if (last_cnt !== 1 || lastf[N-1] !== 1'b1) begin
            errors++;
            $display("FAIL t1_last: got %0d lasts (final=%b), want 1 on beat 511",
                     last_cnt, lastf[N-1]);
        end
        checks++;
        if ({o_valid, o_busy, o_last} !== 3'b000) begin
            errors++;
            $display("FAIL t1_idle_after: got v=%b b=%b l=%b, want 0 0 0", o_valid, o_busy, o_last);
        end
    endtask

    task automatic test_hop_frame();
        int vbad, bad, fb;
        feed_range(512, 638, vbad);
        checks++;
        if (vbad !== 0) begin
            errors++;
            $display("FAIL t2_no_frame_between: active for %0d cycles, want 0", vbad);
        end
        feed(639);
        clear_frame();
        collect(100, N);
        count_bad(128, bad, fb);
        checks++;
        if (nb !== N || bad !== 0) begin
            errors++;
            $display("FAIL t2_data: %0d beats (want %0d), %0d bad, first at %0d got %h want %h",
                     nb, N, bad, fb, beats[fb], 16'(128 + fb));
        end
        checks++;
        if (last_cnt !== 1 || lastf[N-1] !== 1'b1) begin
            errors++;
            $display("FAIL t2_last: got %0d lasts (final=%b), want 1 on beat 511",
                     last_cnt, lastf[N-1]);
        end
    endtask

    task automatic test_random_ready();
        int vbad, bad, fb;
        feed_range(640, 766, vbad);
        feed(767);
        clear_frame();
        collect(50, N);
        count_bad(256, bad, fb);
        checks++;
        if (nb !== N || bad !== 0) begin
            errors++;
            $display("FAIL t3_data: %0d beats (want %0d), %0d bad, first at %0d got %h want %h",
                     nb, N, bad, fb, beats[fb], 16'(256 + fb));
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL t3_stall_hold: %0d unstable stalled cycles, want 0", stall_bad);
        end
        checks++;
        if (last_cnt !== 1 || lastf[N-1] !== 1'b1) begin
            errors++;
            $display("FAIL t3_last: got %0d lasts (final=%b), want 1 on beat 511",
                     last_cnt, lastf[N-1]);
        end
    endtask

    task automatic test_overrun();
        int vbad, bad, fb, hold_bad, o0, idle_bad;
        feed_range(768, 894, vbad);
        feed(895);
        clear_frame();
        collect(100, 300);
        checks++;
        if (nb !== 300) begin
            errors++;
            $display("FAIL t4_partial_count: got %0d, want 300", nb);
        end
        // Stall on beat 300 (sample 384+300) while the next hop worth arrives.
        o0       = ovr_cnt;
        hold_bad = 0;
        i_ready  = 1'b0;
        for (int n = 896; n <= 1023; n++) begin
            feed(n);
            if (o_valid !== 1'b1 || o_data !== 16'd684) hold_bad++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL t4_stall_hold: %0d cycles lost beat 684, want 0", hold_bad);
        end
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL t4_overrun_pulse: high for %0d cycles, want 1", ovr_cnt - o0);
        end
        collect(100, N);
        count_bad(384, bad, fb);
        checks++;
        if (nb !== N || bad !== 0) begin
            errors++;
            $display("FAIL t4_data: %0d beats (want %0d), %0d bad, first at %0d got %h want %h",
                     nb, N, bad, fb, beats[fb], 16'(384 + fb));
        end
        idle_bad = 0;
        for (int c = 0; c < 600; c++) begin
            if (o_valid === 1'b1 || o_busy === 1'b1) idle_bad++;
            @(negedge clk);
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL t4_dropped_not_sent: active for %0d cycles, want 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int vbad, bad, fb;
        feed_range(1024, 1150, vbad);
        feed(1151);
        clear_frame();
        collect(100, 200);
        count_bad(640, bad, fb);
        checks++;
        if (nb !== 200 || bad !== 0) begin
            errors++;
            $display("FAIL t5_pre_reset: %0d beats (want 200), %0d bad", nb, bad);
        end
        #2 RESET = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_last, o_busy, o_data} !== 19'h0) begin
            errors++;
            $display("FAIL t5_async_reset: got v=%b l=%b b=%b d=%h, want all 0",
                     o_valid, o_last, o_busy, o_data);
        end
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        feed_range(1152, 1662, vbad);
        checks++;
        if (vbad !== 0) begin
            errors++;
            $display("FAIL t5_refill_quiet: active for %0d cycles, want 0", vbad);
        end
        feed(1663);
        clear_frame();
        collect(100, N);
        count_bad(1152, bad, fb);
        checks++;
        if (nb !== N || bad !== 0) begin
            errors++;
            $display("FAIL t5_data: %0d beats (want %0d), %0d bad, first at %0d got %h want %h",
                     nb, N, bad, fb, beats[fb], 16'(1152 + fb));
        end
    endtask

    task automatic test_quantisation();
        int vbad;
        feed_raw(24'h7FFFFF);
        feed_raw(24'h800000);
        feed_raw(24'h0000FF);
        feed_range(1667, 1790, vbad);
        feed(1791);
        clear_frame();
        collect(100, N);
        checks++;
        if (nb !== N) begin
            errors++;
            $display("FAIL q_beat_count: got %0d, want %0d", nb, N);
        end
        checks++;
        if (beats[384] !== 16'h7FFF) begin
            errors++;
            $display("FAIL q_max_pos: got %h, want 7fff", beats[384]);
        end
        checks++;
        if (beats[385] !== 16'h8000) begin
            errors++;
            $display("FAIL q_max_neg: got %h, want 8000", beats[385]);
        end
        checks++;
        if (beats[386] !== 16'h0000) begin
            errors++;
            $display("FAIL q_lsb_drop: got %h, want 0000", beats[386]);
        end
        checks++;
        if (beats[0] !== 16'd1280 || beats[387] !== 16'd1667) begin
            errors++;
            $display("FAIL q_neighbours: got %h %h, want 0500 0683", beats[0], beats[387]);
        end
    endtask

    task automatic test_hop_one();
        logic [15:0] srec [32];
        logic        sl   [32];
        int          snb, o0, bad, last_bad;
        snb = 0;
        o0  = s_ovr_cnt;
        for (int i = 0; i < 32; i++) begin
            srec[i] = '0;
            sl[i]   = 1'b0;
        end
        // Samples 0..7 back to back, then 8,9,10 spaced so each lands on
        // the final handshake of the previous frame.
        for (int c = 0; c < 50; c++) begin
            if (s_valid === 1'b1) begin
                if (snb < 32) begin
                    srec[snb] = s_data;
                    sl[snb]   = s_last;
                end
                snb++;
            end
            if (c < 8) begin
                s_start  = 1'b1;
                s_sample = 24'(c << 8);
            end else if (c <= 34 && (c - 7) % 9 == 0) begin
                s_start  = 1'b1;
                s_sample = 24'(((c - 7) / 9 + 7) << 8);
            end else begin
                s_start = 1'b0;
            end
            @(negedge clk);
        end
        s_start = 1'b0;
        checks++;
        if (snb !== 32) begin
            errors++;
            $display("FAIL h1_beat_count: got %0d, want 32", snb);
        end
        bad      = 0;
        last_bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (srec[i] !== 16'(i / 8 + i % 8)) bad++;
            if (sl[i] !== (i % 8 == 7)) last_bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL h1_data: %0d bad beats, want 0", bad);
        end
        checks++;
        if (last_bad !== 0) begin
            errors++;
            $display("FAIL h1_last: %0d misplaced o_last, want 0", last_bad);
        end
        checks++;
        if (s_ovr_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL h1_no_overrun: got %0d pulses, want 0", s_ovr_cnt - o0);
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL h1_idle_after: got busy=%b, want 0", s_busy);
        end
    endtask

    initial begin
        RESET         = 1'b0;
        start_compute = 1'b0;
        i_SAMPLE      = '0;
        i_ready       = 1'b1;
        s_start       = 1'b0;
        s_sample      = '0;
        s_ready       = 1'b1;
        @(negedge clk);
        test_reset();
        test_first_frame();
        test_hop_frame();
        test_random_ready();
        test_overrun();
        test_reset_mid_frame();
        test_quantisation();
        test_hop_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
